// File: rtl/fma_stim_pkg.sv
// Shared types and default sizing for the FMA stimulus controller.
package fma_stim_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_VEC = 8;
  localparam int DEF_MAX_OUT = 4;
  localparam int DEF_TIMEOUT = 256;

endpackage

// File: rtl/stim_exp_fifo.sv
// Expected-result FIFO: show-ahead read, pop on empty ignored, push on full
// accepted only when a pop frees the slot in the same cycle.
module stim_exp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
      if (do_pop)  rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_q] <= push_data;
  end

endmodule

// File: rtl/fma_stim_ctrl.sv
// Vector-table stimulus/checker for an FMA unit under test.
// Define STIM_ULP_TOL_EN to accept results within 1 raw ULP of the expected value.
module fma_stim_ctrl
  import fma_stim_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_VEC)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]           cfg_a,
  input  logic [WIDTH-1:0]           cfg_b,
  input  logic [WIDTH-1:0]           cfg_c,
  input  logic [WIDTH-1:0]           cfg_exp,
  output logic [WIDTH-1:0]           fp16_a,
  output logic [WIDTH-1:0]           fp16_b,
  output logic [WIDTH-1:0]           fp16_c,
  output logic                       in_valid,
  input  logic [WIDTH-1:0]           fp16_d,
  input  logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_cnt,
  output logic                       timeout
);

  localparam int IW = $clog2(NUM_VEC);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [WIDTH-1:0] tbl_a [NUM_VEC];
  logic [WIDTH-1:0] tbl_b [NUM_VEC];
  logic [WIDTH-1:0] tbl_c [NUM_VEC];
  logic [WIDTH-1:0] tbl_e [NUM_VEC];

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             in_valid_q, in_valid_d, busy_q, busy_d, done_q, done_d;
  logic             pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0]      err_q, err_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic             resp, issue, mism, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [WIDTH-1:0] exp_head;

  function automatic logic exp_match(input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
`ifdef STIM_ULP_TOL_EN
    logic [WIDTH-1:0] diff;
    diff = (got >= want) ? got - want : want - got;
    return (got[WIDTH-1] == want[WIDTH-1]) && (diff <= WIDTH'(1));
`else
    return got == want;
`endif
  endfunction

  stim_exp_fifo #(.WIDTH(WIDTH), .DEPTH(MAX_OUT)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fifo_clr),
    .push     (issue),
    .push_data(tbl_e[idx_q]),
    .pop      (fifo_pop),
    .pop_data (exp_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    resp     = (state_q == S_RUN || state_q == S_DRAIN) && out_valid;
    fifo_pop = resp && !fifo_empty;
    issue    = (state_q == S_RUN) && (!fifo_full || fifo_pop);
    fifo_clr = (state_q == S_IDLE) && start;
    mism     = resp && (fifo_empty || !exp_match(fp16_d, exp_head));

    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    in_valid_d = 1'b0;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          idx_d     = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          tcnt_d    = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        if (issue) begin
          a_d        = tbl_a[idx_q];
          b_d        = tbl_b[idx_q];
          c_d        = tbl_c[idx_q];
          in_valid_d = 1'b1;
          idx_d      = idx_q + IW'(1);
          if (idx_q == IW'(NUM_VEC - 1)) state_d = S_DRAIN;
        end
        if (mism && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (resp)             tcnt_d = '0;
        else if (!fifo_empty) tcnt_d = tcnt_q + TW'(1);
        if (state_q == S_DRAIN && fifo_empty) state_d = S_DONE;
        // A stalled response aborts the run from either RUN or DRAIN.
        if (!resp && !fifo_empty && tcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      done_d = 1'b1;
      pass_d = (err_d == 16'd0) && !timeout_d;
    end
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      in_valid_q <= in_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cfg_we) begin
      tbl_a[cfg_addr] <= cfg_a;
      tbl_b[cfg_addr] <= cfg_b;
      tbl_c[cfg_addr] <= cfg_c;
      tbl_e[cfg_addr] <= cfg_exp;
    end
  end

  assign fp16_a   = a_q;
  assign fp16_b   = b_q;
  assign fp16_c   = c_q;
  assign in_valid = in_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign timeout  = timeout_q;

endmodule
